// File: rtl/led7seg_count_scheduler.sv
// Two-digit BCD counter with run/pause control, up/down stepping and load,
// time-multiplexed onto anodes 0 (ones) and 1 (tens) of a 4-digit 7-segment display.
module led7seg_count_scheduler #(
   parameter int CNT_DIV  = 2500000,
   parameter int SCAN_DIV = 100000,
   parameter bit BLANK_LZ = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_run,
   input  logic       dir,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] value,
   output logic       wrap,
   output logic       running,
   output logic [6:0] seg,
   output logic [3:0] an_out
);

   localparam int CW = (CNT_DIV > 2) ? $clog2(CNT_DIV) : 1;
   localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

   // Handshake: none. btn_run and load are single-cycle pulses sampled on every
   // rising edge; value/wrap/running/seg/an_out are registered, one-cycle latency.

   typedef enum logic {
      PAUSE = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt_pre, cnt_pre_nxt;
   logic [SW-1:0]   scan_pre;
   logic            sel;
   logic            step;
   logic [7:0]      value_nxt;
   logic            wrap_nxt;
   logic [6:0]      seg_nxt;
   logic [3:0]      an_nxt;

   function automatic logic [3:0] clamp9(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   function automatic logic [6:0] dec7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   always_comb begin
      state_nxt = state;
      if (btn_run) state_nxt = (state == RUN) ? PAUSE : RUN;
   end

   assign step = (state == RUN) && (cnt_pre == CNT_LAST);

   // Prescaler sits at 0 whenever paused (or about to pause) and restarts on load,
   // so the first step lands exactly CNT_DIV cycles after entering RUN or loading.
   always_comb begin
      cnt_pre_nxt = '0;
      if (!load && state == RUN && state_nxt == RUN && cnt_pre != CNT_LAST)
         cnt_pre_nxt = cnt_pre + CW'(1);
   end

   always_comb begin
      value_nxt = value;
      wrap_nxt  = 1'b0;
      if (load) begin
         value_nxt = {clamp9(load_val[7:4]), clamp9(load_val[3:0])};
      end else if (step) begin
         if (dir) begin
            if (value[3:0] == 4'd9) begin
               value_nxt[3:0] = 4'd0;
               if (value[7:4] == 4'd9) begin
                  value_nxt[7:4] = 4'd0;
                  wrap_nxt       = 1'b1;
               end else begin
                  value_nxt[7:4] = value[7:4] + 4'd1;
               end
            end else begin
               value_nxt[3:0] = value[3:0] + 4'd1;
            end
         end else begin
            if (value[3:0] == 4'd0) begin
               value_nxt[3:0] = 4'd9;
               if (value[7:4] == 4'd0) begin
                  value_nxt[7:4] = 4'd9;
                  wrap_nxt       = 1'b1;
               end else begin
                  value_nxt[7:4] = value[7:4] - 4'd1;
               end
            end else begin
               value_nxt[3:0] = value[3:0] - 4'd1;
            end
         end
      end
   end

   // Anode and segments come from one register stage, so only one anode is ever low.
   always_comb begin
      seg_nxt = 7'h7F;
      an_nxt  = 4'hF;
      if (!sel) begin
         an_nxt  = 4'b1110;
         seg_nxt = dec7(value[3:0]);
      end else begin
         an_nxt  = 4'b1101;
         seg_nxt = (BLANK_LZ && value[7:4] == 4'd0) ? 7'h7F : dec7(value[7:4]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= PAUSE;
         running  <= 1'b0;
         cnt_pre  <= '0;
         value    <= 8'h00;
         wrap     <= 1'b0;
         scan_pre <= '0;
         sel      <= 1'b0;
         seg      <= 7'h7F;
         an_out   <= 4'hF;
      end else begin
         state    <= state_nxt;
         running  <= (state_nxt == RUN);
         cnt_pre  <= cnt_pre_nxt;
         value    <= value_nxt;
         wrap     <= wrap_nxt;
         scan_pre <= (scan_pre == SCAN_LAST) ? '0 : scan_pre + SW'(1);
         sel      <= sel ^ (scan_pre == SCAN_LAST);
         seg      <= seg_nxt;
         an_out   <= an_nxt;
      end
   end

endmodule

// File: doc/led7seg_count_scheduler.md
Name: led7seg_count_scheduler

Overview:
Controller that sequences a two-digit BCD 00–99 counter and time-multiplexes it onto the 4-anode 7-segment display. It generates its own count and scan ticks from the system clock and has a run/pause FSM, an up/down direction input and a synchronous load. It sits between the board buttons (debounced upstream) and the seg/an pins. It replaces the ad-hoc divider, counter and anode-select chain.

Parameters:
CNT_DIV, 2500000, clk cycles per count step (40 Hz at 100 MHz); must be ≥2.
SCAN_DIV, 100000, clk cycles per digit switch (1 kHz at 100 MHz); must be ≥2.
BLANK_LZ, 0, 1 = blank the tens digit when tens==0.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous, active-low reset.
btn_run  input  1  single-cycle pulse; toggles RUN/PAUSE.
dir  input  1  1 = count up, 0 = count down; sampled at each step.
load  input  1  single-cycle pulse; loads load_val.
load_val  input  8  BCD {tens[7:4], ones[3:0]}.
value  output  8  current BCD count {tens, ones}.
wrap  output  1  one-cycle pulse on 99→00 (up) or 00→99 (down).
running  output  1  1 while in RUN.
seg  output  7  active-low segments {g,f,e,d,c,b,a}.
an_out  output  4  active-low anodes; only an_out[1:0] are ever driven low.

Behaviour:
- Reset (rst=0, async): state=PAUSE, value=8'h00, wrap=0, running=0, seg=7'h7F, an_out=4'hF, both prescalers=0, digit select sel=0.
- FSM has two states, PAUSE and RUN. btn_run toggles the state. running is registered and equals (state==RUN).
- Count prescaler:
  - Held at 0 in PAUSE.
  - In RUN it counts 0..CNT_DIV-1 and issues step when at CNT_DIV-1, then returns to 0.
  - The first step occurs CNT_DIV cycles after the cycle in which RUN is entered.
- Step up: ones 9→0 with tens+1. 99→00 asserts wrap for that cycle.
- Step down: ones 0→9 with tens-1. 00→99 asserts wrap.
- Load:
  - value <= load_val, with any digit >9 clamped to 9.
  - Count prescaler is cleared to 0.
  - Run state is unchanged.
  - No wrap is generated.
- Simultaneous events:
  - load with step: load wins and the step is discarded.
  - btn_run with load: both take effect.
  - btn_run with step: the step is applied, then the state toggles.
- value and wrap update on the clock edge after the step/load cycle (registered, 1-cycle latency).
- Scan prescaler:
  - Free-runs in both states, counting 0..SCAN_DIV-1.
  - At SCAN_DIV-1, sel toggles.
- Output register (updated every cycle, reflects sel/value of the previous cycle):
  - sel=0: an_out=4'b1110, seg=dec(ones).
  - sel=1: an_out=4'b1101, seg=dec(tens), or 7'h7F if BLANK_LZ=1 and tens==0.
- Decoder dec (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other code → 7'h7F.
- Reset mid-count: everything returns to reset values immediately. After release the counter stays in PAUSE until btn_run.
- Never more than one anode is active at a time. There is no glitch cycle with two anodes low.

Test Plan:
1. CNT_DIV=4, SCAN_DIV=3. Release reset and hold btn_run low for 20 cycles → value=00, running=0. seg/an_out alternate between 1000000/1110 and 1000000/1101 every 3 cycles.
2. Pulse btn_run, dir=1 → running=1. value becomes 01 four cycles after RUN entry, then 02, 03 every 4 cycles. Pulse btn_run again → value frozen.
3. Load 8'h98, dir=1, then RUN → 99, then 00 with wrap=1 for exactly one cycle. Repeat with dir=0 from load 8'h01 → 00, then 99 with wrap=1.
4. Load 8'h3C (invalid ones digit) → value=8'h39. Load asserted in the same cycle as a step → value=load_val, no step applied, next step CNT_DIV cycles later.
5. BLANK_LZ=1, value=07 → tens phase gives seg=7'h7F, an_out=1101; ones phase gives seg=1111000, an_out=1110.
6. Assert rst low mid-RUN at value 57, asynchronously (between clock edges) → seg=7F, an_out=F, value=00, running=0 immediately. After release, value stays 00 with no btn_run.
